// File: rtl/txword_queue_pkg.sv
// Shared constants for the hex-word report path: word width and printer frame length.
package txword_queue_pkg;

  localparam int unsigned WordWidth = 32;
  // "0xXXXXXXXX\r\n"
  localparam int unsigned FrameLen  = 12;

  typedef logic [WordWidth-1:0] word_t;

  // Clocks the printer needs for one full frame at 10 bit-times per character.
  function automatic int unsigned frame_clocks(input int unsigned clks_per_baud);
    return FrameLen * 10 * clks_per_baud;
  endfunction

endpackage

// File: rtl/sfifo_word.sv
// Plain synchronous word FIFO; exposes the entry behind the head for fall-through refill.
module sfifo_word
  import txword_queue_pkg::*;
#(
  parameter int unsigned LGFLEN = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              wr,
  input  word_t             wr_data,
  input  logic              rd,
  output word_t             next_data,
  output logic [LGFLEN:0]   fill,
  output logic              full
);

  localparam int unsigned   Depth  = 1 << LGFLEN;
  localparam int unsigned   FW     = LGFLEN + 1;
  localparam logic [LGFLEN:0] DepthW = FW'(Depth);

  word_t             mem [Depth];
  logic [LGFLEN-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              full_q;

  assign rd_ptr_nxt = rd_ptr_q + 1'b1;
  assign next_data  = mem[rd_ptr_nxt];
  assign fill       = fill_q;
  assign full       = full_q;

  always_comb begin
    fill_d = fill_q;
    unique case ({wr, rd})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr && !i_reset) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_nxt;
      fill_q <= fill_d;
      full_q <= (fill_d == DepthW);
    end
  end

endmodule

// File: rtl/txword_queue.sv
// Report-word queue feeding the hex UART printer: FIFO, optional dedup, overflow count,
// and a registered first-word-fall-through presentation stage.
module txword_queue
  import txword_queue_pkg::*;
#(
  parameter int unsigned LGFLEN       = 3,
  parameter bit          OPT_ONCHANGE = 1'b0,
  parameter int unsigned OVW          = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [31:0]       i_data,
  output logic              o_stb,
  output logic [31:0]       o_data,
  input  logic              i_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_full,
  output logic [OVW-1:0]    o_overflow
);

  localparam int unsigned FW = LGFLEN + 1;

  logic            pop, dup, accept, ovf_inc;
  logic            stb_d;
  word_t           data_d, next_data;
  word_t           last_q;
  logic            last_valid_q;
  logic [LGFLEN:0] fill, fill_after_pop;
  logic            full;

  assign pop     = o_stb && !i_busy;
  assign dup     = OPT_ONCHANGE && last_valid_q && (i_data == last_q);
  assign accept  = i_wr && (!full || pop) && !dup;
  assign ovf_inc = i_wr && full && !pop && !dup;

  assign o_fill = fill;
  assign o_full = full;

  sfifo_word #(
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .wr        (accept),
    .wr_data   (i_data),
    .rd        (pop),
    .next_data (next_data),
    .fill      (fill),
    .full      (full)
  );

  // The presented word is the FIFO head, mirrored into a register so o_data is glitch-free.
  always_comb begin
    fill_after_pop = fill - FW'(pop);
    stb_d          = (fill_after_pop != '0) || accept;
    data_d         = o_data;
    if (pop && (fill > FW'(1))) begin
      data_d = next_data;
    end else if ((fill_after_pop == '0) && accept) begin
      data_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stb        <= 1'b0;
      o_data       <= '0;
      o_overflow   <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      o_stb  <= stb_d;
      o_data <= data_d;
      if (accept) begin
        last_q       <= i_data;
        last_valid_q <= 1'b1;
      end
      if (ovf_inc && (o_overflow != '1)) begin
        o_overflow <= o_overflow + 1'b1;
      end
    end
  end

endmodule
